// File: rtl/writeback_queue_if.sv
// writeback_queue_if: producer handshakes, register-file write port and status (bypass lookups when WB_BYPASS_EN is defined)
interface writeback_queue_if #(
    parameter int CNT_W = 3
);
    logic             alu_valid;
    logic             alu_ready;
    logic [4:0]       alu_addr;
    logic [31:0]      alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [4:0]       mem_addr;
    logic [31:0]      mem_data;
    logic [4:0]       address_wr;
    logic [31:0]      wr_data;
    logic             wr_en;
    logic [CNT_W-1:0] count;
    logic             idle;
`ifdef WB_BYPASS_EN
    logic [4:0]       byp_addr_0;
    logic [4:0]       byp_addr_1;
    logic             byp_hit_0;
    logic             byp_hit_1;
    logic [31:0]      byp_data_0;
    logic [31:0]      byp_data_1;
`endif

    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, address_wr, wr_data, wr_en, count, idle
`ifdef WB_BYPASS_EN
        , output byp_addr_0, byp_addr_1,
        input  byp_hit_0, byp_hit_1, byp_data_0, byp_data_1
`endif
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, address_wr, wr_data, wr_en, count, idle
`ifdef WB_BYPASS_EN
        , input byp_addr_0, byp_addr_1,
        output byp_hit_0, byp_hit_1, byp_data_0, byp_data_1
`endif
    );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO merging ALU and load results onto one register-file write port; WB_BYPASS_EN adds two forwarding lookups
module writeback_queue #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    writeback_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       out_addr;
    logic [31:0]      out_data;
    logic             out_en;
    logic             mem_push;
    logic             alu_push;
    logic             pop;

    // Readiness looks only at occupancy before the edge, so a same-cycle pop never frees a slot
    assign bus.mem_ready = cnt != CNT_W'(DEPTH);
    assign bus.alu_ready = bus.mem_valid ? (cnt < CNT_W'(DEPTH - 1)) : (cnt != CNT_W'(DEPTH));
    assign mem_push = bus.mem_valid && bus.mem_ready && bus.mem_addr != 5'd0;
    assign alu_push = bus.alu_valid && bus.alu_ready && bus.alu_addr != 5'd0;
    assign pop = cnt != '0;

    assign bus.address_wr = out_addr;
    assign bus.wr_data = out_data;
    assign bus.wr_en = out_en;
    assign bus.count = cnt;
    assign bus.idle = !pop && !out_en;

    // Entry storage: the load result takes the first free slot, the ALU result the one after it
    always_ff @(posedge clk) begin
        if (mem_push) begin
            addr_q[wr_ptr] <= bus.mem_addr;
            data_q[wr_ptr] <= bus.mem_data;
        end
        if (alu_push) begin
            addr_q[wr_ptr + AW'(mem_push)] <= bus.alu_addr;
            data_q[wr_ptr + AW'(mem_push)] <= bus.alu_data;
        end
    end

    // Pointers, occupancy and the registered write port; the head drains every cycle it exists
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
            out_en <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(mem_push) + AW'(alu_push);
            cnt <= cnt + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
            out_en <= pop;
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                out_addr <= addr_q[rd_ptr];
                out_data <= data_q[rd_ptr];
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Returns {hit, data}; walking oldest to youngest lets the youngest match overwrite older ones
    function automatic logic [32:0] lookup(input logic [4:0] a);
        logic [32:0] r;
        r = (out_en && out_addr == a) ? {1'b1, out_data} : 33'd0;
        for (int i = 0; i < DEPTH; i++)
            if (CNT_W'(i) < cnt && addr_q[rd_ptr + AW'(i)] == a) r = {1'b1, data_q[rd_ptr + AW'(i)]};
        return (a == 5'd0) ? 33'd0 : r;
    endfunction

    // Forwarding lookups for decode
    always_comb begin
        {bus.byp_hit_0, bus.byp_data_0} = lookup(bus.byp_addr_0);
        {bus.byp_hit_1, bus.byp_data_1} = lookup(bus.byp_addr_1);
    end
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: random and directed stimulus against a queue-based model of the writeback queue
module tb_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_errors = 0;

    entry_t q[$];
    logic exp_en = 1'b0;
    logic [4:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [4:0] b0 = '0;
    logic [4:0] b1 = '0;

    writeback_queue_if #(.CNT_W(3)) bus ();
    writeback_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model_byp(input logic [4:0] a);
        if (a == 5'd0) return 33'd0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == a) return {1'b1, q[i].d};
        if (exp_en && exp_addr == a) return {1'b1, exp_data};
        return 33'd0;
    endfunction

    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        logic mr, ar;
        @(negedge clk);
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
`ifdef WB_BYPASS_EN
        bus.byp_addr_0 = b0; bus.byp_addr_1 = b1;
`endif
        #1;
        mr = q.size() < DEPTH;
        ar = q.size() < DEPTH - (mv ? 1 : 0);
        check("mem_ready", 64'(bus.mem_ready), 64'(mr));
        check("alu_ready", 64'(bus.alu_ready), 64'(ar));
`ifdef WB_BYPASS_EN
        check("byp0", 64'({bus.byp_hit_0, bus.byp_data_0}), 64'(model_byp(b0)));
        check("byp1", 64'({bus.byp_hit_1, bus.byp_data_1}), 64'(model_byp(b1)));
`endif
        @(posedge clk);
        #1;
        exp_en = q.size() > 0;
        if (exp_en) begin
            entry_t e;
            e = q.pop_front();
            exp_addr = e.a;
            exp_data = e.d;
        end
        if (mv && mr && ma != 5'd0) q.push_back('{a: ma, d: md});
        if (av && ar && aa != 5'd0) q.push_back('{a: aa, d: ad});
        check("wr_en", 64'(bus.wr_en), 64'(exp_en));
        check("address_wr", 64'(bus.address_wr), 64'(exp_addr));
        check("wr_data", 64'(bus.wr_data), 64'(exp_data));
        check("count", 64'(bus.count), 64'(q.size()));
        check("idle", 64'(bus.idle), 64'(q.size() == 0 && !exp_en));
    endtask

    task automatic idle_step();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
`ifdef WB_BYPASS_EN
        bus.byp_addr_0 = '0; bus.byp_addr_1 = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_idle", 64'(bus.idle), 64'd1);
        check("rst_addr", 64'(bus.address_wr), 64'd0);
        check("rst_data", 64'(bus.wr_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // single ALU write: visible one edge after acceptance, gone the edge after
        step(1'b1, 5'd5, 32'h11111111, 1'b0, 5'd0, 32'd0);
        check("single_wait", 64'(bus.wr_en), 64'd0);
        idle_step();
        check("single_addr", 64'(bus.address_wr), 64'd5);
        check("single_data", 64'(bus.wr_data), 64'h11111111);
        idle_step();
        check("single_done", 64'(bus.idle), 64'd1);

        // dual acceptance: load entry ahead of ALU entry
        step(1'b1, 5'd4, 32'h0000BBBB, 1'b1, 5'd3, 32'hAAAA0000);
        check("dual_count", 64'(bus.count), 64'd2);
        idle_step();
        check("dual_first", 64'(bus.address_wr), 64'd3);
        idle_step();
        check("dual_second", 64'(bus.address_wr), 64'd4);
        idle_step();

        // $zero write consumes a handshake but nothing else
        step(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        check("zero_count", 64'(bus.count), 64'd0);
        idle_step();
        check("zero_no_write", 64'(bus.wr_en), 64'd0);

        // continuous dual offers: ALU back-pressured near full
        for (int i = 0; i < 8; i++)
            step(1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b1, 5'(i + 9), 32'hB000 + 32'(i));
        repeat (5) idle_step();

        // async reset with three entries pending
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        step(1'b1, 5'd3, 32'h3, 1'b1, 5'd6, 32'h6);
        check("pre_rst_count", 64'(bus.count), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_wr_en", 64'(bus.wr_en), 64'd0);
        check("async_count", 64'(bus.count), 64'd0);
        check("async_idle", 64'(bus.idle), 64'd1);
        q.delete();
        exp_en = 1'b0; exp_addr = '0; exp_data = '0;
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle_step();

`ifdef WB_BYPASS_EN
        // forwarding returns the youngest value, then the output register, then misses
        step(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
        bus.byp_addr_0 = 5'd7;
        #1;
        check("byp_young_hit", 64'(bus.byp_hit_0), 64'd1);
        check("byp_young_data", 64'(bus.byp_data_0), 64'h2);
        b0 = 5'd7;
        repeat (2) idle_step();
        #1;
        check("byp_drained", 64'(bus.byp_hit_0), 64'd0);
        check("byp_miss_data", 64'(bus.byp_data_0), 64'd0);
`endif

        // random traffic with alternating heavy and light offer rates
        for (int i = 0; i < 400; i++) begin
            int p;
            p = ((i / 40) % 2 == 0) ? 90 : 25;
            b0 = 5'($urandom_range(0, 7));
            b1 = 5'($urandom_range(0, 7));
            step($urandom_range(0, 99) < p, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 99) < p, 5'($urandom_range(0, 7)), $urandom);
        end
        repeat (6) idle_step();
        check("final_idle", 64'(bus.idle), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
